// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift on device clocks, ack check.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN (aborts after TIMEOUT_CYCLES from REQ).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_PRE  = INH_W'((INHIBIT_CYCLES > 1) ? INHIBIT_CYCLES - 2 : 0);
  localparam logic INH_ONE = (INHIBIT_CYCLES == 1);

  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  logic       clk_sync;
  logic       data_sync;
  logic       clk_sync3_reg;
  logic       fall;

  genvar gi;

  assign pin_raw = {ps2_data_in, ps2_clk_in};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic sync1_reg;
      logic sync2_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= pin_raw[gi];
          sync2_reg <= sync1_reg;
        end
      end
      assign pin_sync[gi] = sync2_reg;
    end
  endgenerate

  assign clk_sync  = pin_sync[0];
  assign data_sync = pin_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync3_reg <= 1'b1;
    end else begin
      clk_sync3_reg <= clk_sync;
    end
  end

  assign fall = ~clk_sync & clk_sync3_reg;

  logic [2:0]       state_reg, state_next;
  logic [7:0]       byte_reg, byte_next;
  logic             parity_reg, parity_next;
  logic [3:0]       edge_cnt_reg, edge_cnt_next;
  logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
  logic             ack_reg, ack_next;
  logic             clk_oe_reg, clk_oe_next;
  logic             data_oe_reg, data_oe_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             wd_expired;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            wd_active;

  // The watchdog runs from REQ entry; the REQ cycle itself is count zero.
  assign wd_active   = (state_reg != S_IDLE) && (state_reg != S_INHIBIT);
  assign wd_cnt_next = wd_active ? wd_cnt_reg + 1'b1 : '0;
  assign wd_expired  = wd_active && (wd_cnt_reg == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    byte_next     = byte_reg;
    parity_next   = parity_reg;
    edge_cnt_next = edge_cnt_reg;
    inh_cnt_next  = inh_cnt_reg;
    ack_next      = ack_reg;
    clk_oe_next   = clk_oe_reg;
    data_oe_next  = data_oe_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (tx_valid) begin
          byte_next     = tx_byte;
          parity_next   = ~^tx_byte;
          edge_cnt_next = 4'd0;
          inh_cnt_next  = '0;
          clk_oe_next   = 1'b1;
          data_oe_next  = INH_ONE;
          state_next    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        inh_cnt_next = inh_cnt_reg + 1'b1;
        // Start bit appears on the final inhibit cycle, so arm it one cycle early.
        if (!INH_ONE && inh_cnt_reg == INH_PRE) data_oe_next = 1'b1;
        if (inh_cnt_reg == INH_LAST) state_next = S_REQ;
      end
      S_REQ: begin
        clk_oe_next = 1'b0;
        state_next  = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          edge_cnt_next = edge_cnt_reg + 4'd1;
          if (edge_cnt_reg < 4'd8) begin
            data_oe_next = ~byte_reg[edge_cnt_reg[2:0]];
          end else if (edge_cnt_reg == 4'd8) begin
            data_oe_next = ~parity_reg;
          end else begin
            data_oe_next = 1'b0;
            state_next   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_next   = ~data_sync;
          state_next = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          done_next  = ack_reg;
          err_next   = ~ack_reg;
          state_next = S_IDLE;
        end
      end
      default: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        state_next   = S_IDLE;
      end
    endcase
    if (wd_expired) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      done_next    = 1'b0;
      err_next     = 1'b1;
      state_next   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      byte_reg     <= 8'h00;
      parity_reg   <= 1'b0;
      edge_cnt_reg <= 4'd0;
      inh_cnt_reg  <= '0;
      ack_reg      <= 1'b0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      parity_reg   <= parity_next;
      edge_cnt_reg <= edge_cnt_next;
      inh_cnt_reg  <= inh_cnt_next;
      ack_reg      <= ack_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign tx_ready    = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_done     = done_reg;
  assign tx_err      = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model plus a simple PS/2 device that clocks and acks.
module tb_ps2_host_tx;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  logic dev_clk_low;
  logic dev_data_low;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int clk_oe_cnt = 0;
  int busy_cnt = 0;
  int k, e0, b0;

  always #5 clk = ~clk;

  // Wired-AND bus with pull-ups: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_byte(tx_byte),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_err(tx_err)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (ps2_clk_oe) clk_oe_cnt <= clk_oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full host frame with the device model clocking 11 pulses.
  task automatic frame(input string nm, input logic [7:0] b, input logic par, input bit ack,
                       input bit keep_valid, input logic [7:0] next_byte);
    int w, hi, d0, er0, oe0;
    logic [9:0] bits;
    d0 = done_cnt;
    er0 = err_cnt;
    w = 0;
    while (!ps2_clk_oe && w < 10) begin tick(); w++; end
    check({nm, "_inhibit_start"}, 32'(ps2_clk_oe), 1);
    check({nm, "_busy"}, 32'(busy), 1);
    if (keep_valid) tx_byte = next_byte;
    else tx_valid = 1'b0;
    hi = 0;
    while (ps2_clk_oe && hi < 100) begin hi++; tick(); end
    // INHIBIT cycles followed by the single REQ cycle
    check({nm, "_clk_oe_cycles"}, hi, INHIBIT + 1);
    check({nm, "_start_bit"}, 32'(ps2_data_oe), 1);
    oe0 = clk_oe_cnt;
    bits = '0;
    for (int i = 1; i <= 11; i++) begin
      repeat (5) tick();
      if (i == 11 && ack) dev_data_low = 1'b1;
      repeat (3) tick();
      dev_clk_low = 1'b1;
      repeat (20) tick();
      dev_clk_low = 1'b0;
      if (i <= 10) begin
        bits[i-1] = ps2_data_in;
        repeat (20) tick();
      end
    end
    dev_data_low = 1'b0;
    check({nm, "_bits"}, 32'(bits), 32'({1'b1, par, b}));
    check({nm, "_no_restart"}, clk_oe_cnt - oe0, 0);
    w = 0;
    while (!tx_done && !tx_err && w < 100) begin tick(); w++; end
    check({nm, "_ready_at_end"}, 32'(tx_ready), 1);
    check({nm, "_clk_released"}, 32'(ps2_clk_oe), 0);
    check({nm, "_done"}, 32'(tx_done), ack ? 1 : 0);
    check({nm, "_err"}, 32'(tx_err), ack ? 0 : 1);
    tick();
    check({nm, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
    check({nm, "_err_pulses"}, err_cnt - er0, ack ? 0 : 1);
    check({nm, "_never_both"}, both_cnt, 0);
    $display("[TB] frame %s byte=%02h bits=%03h ack=%0d done=%0d err=%0d",
             nm, b, bits, ack, done_cnt - d0, err_cnt - er0);
  endtask

  initial begin
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_byte = 8'h00;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_err", 32'(tx_err), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 0xED with ack: odd parity bit 1
    tx_byte = 8'hED; tx_valid = 1'b1;
    frame("ed", 8'hED, 1'b1, 1'b1, 1'b0, 8'h00);

    // 0x00 then 0x07 back to back, tx_valid held through the first frame
    tx_byte = 8'h00; tx_valid = 1'b1;
    frame("b2b_00", 8'h00, 1'b1, 1'b1, 1'b1, 8'h07);
    frame("b2b_07", 8'h07, 1'b0, 1'b1, 1'b0, 8'h00);

    // Device leaves data high on the ack clock
    tx_byte = 8'h55; tx_valid = 1'b1;
    frame("nack", 8'h55, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) tick();
    check("nack_idle", 32'(tx_ready), 1);

    // Single-cycle glitch on the clock pin while idle
    b0 = busy_cnt;
    dev_clk_low = 1'b1;
    tick();
    dev_clk_low = 1'b0;
    repeat (8) tick();
    check("glitch_busy", busy_cnt - b0, 0);
    check("glitch_ready", 32'(tx_ready), 1);
    check("glitch_clk_oe", 32'(ps2_clk_oe), 0);
    $display("[TB] glitch on idle clock line: busy cycles=%0d", busy_cnt - b0);

    // Device never clocks
    e0 = err_cnt;
    tx_byte = 8'h5A; tx_valid = 1'b1;
    k = 0;
    while (!ps2_clk_oe && k < 10) begin tick(); k++; end
    tx_valid = 1'b0;
    k = 0;
    while (ps2_clk_oe && k < 100) begin tick(); k++; end
`ifdef PS2_TX_TIMEOUT_EN
    // First released cycle is one after REQ entry, so the pulse is TIMEOUT-1 ticks later
    k = 0;
    while (!tx_err && k < 2000) begin tick(); k++; end
    check("to_latency", k, TIMEOUT - 1);
    check("to_clk_oe", 32'(ps2_clk_oe), 0);
    check("to_data_oe", 32'(ps2_data_oe), 0);
    check("to_no_done", 32'(tx_done), 0);
    tick();
    check("to_idle", 32'(tx_ready), 1);
    check("to_err_pulses", err_cnt - e0, 1);
    $display("[TB] timeout transfer: err after %0d cycles", k + 1);
`else
    repeat (600) tick();
    check("hang_busy", 32'(busy), 1);
    check("hang_no_err", err_cnt - e0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("hang_recovered", 32'(tx_ready), 1);
    $display("[TB] silent device: still busy until reset");
`endif

    // Reset during INHIBIT releases the clock line without a clock edge
    tx_byte = 8'hFF; tx_valid = 1'b1;
    k = 0;
    while (!ps2_clk_oe && k < 10) begin tick(); k++; end
    tx_valid = 1'b0;
    repeat (5) tick();
    check("rst_inh_pre", 32'(ps2_clk_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_inh_clk_oe", 32'(ps2_clk_oe), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset during SHIFT after the 4th device clock
    tx_byte = 8'h00; tx_valid = 1'b1;
    k = 0;
    while (!ps2_clk_oe && k < 10) begin tick(); k++; end
    tx_valid = 1'b0;
    k = 0;
    while (ps2_clk_oe && k < 100) begin tick(); k++; end
    for (int i = 1; i <= 4; i++) begin
      repeat (8) tick();
      dev_clk_low = 1'b1;
      repeat (20) tick();
      if (i < 4) begin
        dev_clk_low = 1'b0;
        repeat (20) tick();
      end
    end
    check("rst_shift_pre", 32'(ps2_data_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_shift_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_shift_data_oe", 32'(ps2_data_oe), 0);
    check("rst_shift_busy", 32'(busy), 0);
    dev_clk_low = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_shift_ready", 32'(tx_ready), 1);
    $display("[TB] reset mid-shift: lines released asynchronously");

    tx_byte = 8'hFF; tx_valid = 1'b1;
    frame("ff", 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
